neuron_wb_sequencer: RTL and testbench
======================================

// Module: neuron_wb_sequencer
// PURPOSE
//  Wishbone classic master that drives the neuron core's slave memory map. Accepts
//  typed commands (synapse/param/choose_weight/done_pic write, spike_out read),
//  encodes the target byte address, runs one single-beat bus cycle and returns a
//  status/data response. Sits between the on-chip picture loader and the core slave.
// PARAMETERS
//  BASE_ADDR    32'h3000_0000  base of core map; region offsets are added to it
//  TIMEOUT_CYC  255            max cycles stb may wait for ack (1..255)
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rst_n     in   1   asynchronous active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   command accepted when valid&ready
//  cmd_kind     in   3   0 synapse wr,1 param wr,2 choose_weight wr,3 done_pic wr,4 spike rd
//  cmd_idx      in   8   word index within region (see encoding)
//  cmd_data     in   32  write data (ignored for kind 4)
//  rsp_valid    out  1   response held until rsp_ready
//  rsp_ready    in   1   response consumed
//  rsp_data     out  32  read data (kind 4), else 0
//  rsp_err      out  2   0 ok, 1 illegal kind/index, 2 ack timeout
//  wbm_cyc_o    out  1   Wishbone cycle
//  wbm_stb_o    out  1   Wishbone strobe
//  wbm_we_o     out  1   1 write, 0 read
//  wbm_sel_o    out  4   always 4'hF during a cycle
//  wbm_adr_o    out  32  byte address
//  wbm_dat_o    out  32  write data
//  wbm_dat_i    in   32  read data
//  wbm_ack_i    in   1   slave acknowledge
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=0 while in reset then 1; all other outputs 0.
//  Address encoding (BASE + offset):
//   kind0 synapse   : idx*4,                      idx 0..255 (0x000-0x3FC)
//   kind1 param     : 0x1000 + idx[6:2]*16 + idx[1:0]*4; idx[1:0]=3 or idx[7]=1 illegal
//   kind2 choose_wt : 0x3000 + idx*4,             idx 0..15
//   kind3 done_pic  : 0x3100,                     idx must be 0
//   kind4 spike_out : 0x2000,                     idx must be 0
//   kind 5..7 illegal.
//  FSM IDLE -> BUS -> RESP -> IDLE:
//   IDLE: cmd_ready=1. On valid&ready latch kind/idx/data. Legal -> BUS next cycle
//    with cyc=stb=1, adr/dat/we/sel registered. Illegal -> RESP, err=1, no bus cycle.
//   BUS: cyc/stb/adr/dat/we stable until ack. On ack: capture wbm_dat_i if read,
//    drop cyc/stb next cycle, go RESP err=0. Accept-to-stb latency 1 cycle;
//    ack-to-rsp_valid latency 1 cycle.
//   Timeout counter (8b) clears on BUS entry, increments each BUS cycle without ack;
//    reaching TIMEOUT_CYC -> drop cyc/stb, RESP err=2, rsp_data=0. Ack on the same
//    cycle the count hits TIMEOUT_CYC wins (err=0).
//   RESP: rsp_valid=1, rsp_data/rsp_err stable; rsp_valid&rsp_ready -> IDLE.
//    cmd_ready=0 in BUS and RESP (one outstanding command; no back-to-back overlap).
//  ack outside BUS ignored. wbm_sel_o/adr/dat return to 0 when cyc=0.
//  Reset mid-cycle: cyc/stb drop asynchronously, pending command and response lost.
// TESTING
//  1 kind0 idx=8'h05 data=32'hDEAD_BEEF, ack after 2 cyc -> adr 3000_0014 we=1 sel F; rsp err0
//  2 kind1 idx={num=5'd31,w=2'd2} -> adr 3000_11F8; idx w=3 -> rsp err1, cyc never high
//  3 kind4 idx=0, dat_i=32'h0000_00A5 -> adr 3000_2000 we=0; rsp_data A5 err0
//  4 kind3 idx=0 with no ack, TIMEOUT_CYC=4 -> stb high 4 cyc, drops, rsp err2 data0
//  5 rsp_ready held low 10 cyc -> rsp stable, cmd_ready=0; new cmd accepted after release
//  6 wb_rst_n low during BUS -> cyc/stb=0 immediately; after release cmd_ready=1, rsp_valid=0

Source files
------------

// File: rtl/neuron_wb_sequencer_if.sv
// Command/response handshake and Wishbone classic master signals of the neuron core sequencer.
// The master modport is the sequencer side; the slave modport is the loader plus core side.
interface neuron_wb_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_kind;
  logic [7:0]  cmd_idx;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_kind, cmd_idx, cmd_data, rsp_ready, wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_kind, cmd_idx, cmd_data, rsp_ready, wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/neuron_wb_sequencer.sv
// Wishbone classic master: turns typed neuron-core commands into one single-beat bus
// cycle each and returns a status/data response.
module neuron_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  neuron_wb_sequencer_if.master    bus,
  output logic [1:0]               dbg_state
);

  // Handshakes: a command transfers on a rising edge where cmd_valid & cmd_ready;
  // a response transfers on a rising edge where rsp_valid & rsp_ready. rsp_valid,
  // rsp_data and rsp_err stay constant until that transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  state_t      state;
  logic [7:0]  to_cnt;
  logic        dec_legal;
  logic        dec_we;
  logic [15:0] dec_off;

  assign dbg_state = state;

  // Param words sit on a 16-byte stride with 3 words each, so {idx[6:0],2'b00}
  // is exactly num*16 + w*4.
  always_comb begin
    dec_legal = 1'b0;
    dec_we    = 1'b1;
    dec_off   = 16'h0000;
    case (bus.cmd_kind)
      3'd0: begin
        dec_legal = 1'b1;
        dec_off   = {6'd0, bus.cmd_idx, 2'b00};
      end
      3'd1: begin
        dec_legal = !bus.cmd_idx[7] && (bus.cmd_idx[1:0] != 2'd3);
        dec_off   = 16'h1000 | {7'd0, bus.cmd_idx[6:0], 2'b00};
      end
      3'd2: begin
        dec_legal = (bus.cmd_idx[7:4] == 4'd0);
        dec_off   = 16'h3000 | {10'd0, bus.cmd_idx[3:0], 2'b00};
      end
      3'd3: begin
        dec_legal = (bus.cmd_idx == 8'd0);
        dec_off   = 16'h3100;
      end
      3'd4: begin
        dec_legal = (bus.cmd_idx == 8'd0);
        dec_we    = 1'b0;
        dec_off   = 16'h2000;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state         <= IDLE;
      to_cnt        <= 8'd0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'd0;
      bus.rsp_err   <= 2'd0;
      bus.wbm_cyc_o <= 1'b0;
      bus.wbm_stb_o <= 1'b0;
      bus.wbm_we_o  <= 1'b0;
      bus.wbm_sel_o <= 4'h0;
      bus.wbm_adr_o <= 32'd0;
      bus.wbm_dat_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            if (dec_legal) begin
              state         <= BUS;
              to_cnt        <= 8'd0;
              bus.wbm_cyc_o <= 1'b1;
              bus.wbm_stb_o <= 1'b1;
              bus.wbm_we_o  <= dec_we;
              bus.wbm_sel_o <= 4'hF;
              bus.wbm_adr_o <= BASE_ADDR + {16'd0, dec_off};
              bus.wbm_dat_o <= dec_we ? bus.cmd_data : 32'd0;
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 2'd1;
              bus.rsp_data  <= 32'd0;
            end
          end
        end
        BUS: begin
          // An ack arriving on the same edge the counter expires still completes the cycle.
          if (bus.wbm_ack_i || (8'(to_cnt + 8'd1) == TO_LIMIT)) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.wbm_ack_i ? 2'd0 : 2'd2;
            bus.rsp_data  <= (bus.wbm_ack_i && !bus.wbm_we_o) ? bus.wbm_dat_i : 32'd0;
            bus.wbm_cyc_o <= 1'b0;
            bus.wbm_stb_o <= 1'b0;
            bus.wbm_we_o  <= 1'b0;
            bus.wbm_sel_o <= 4'h0;
            bus.wbm_adr_o <= 32'd0;
            bus.wbm_dat_o <= 32'd0;
          end else begin
            to_cnt <= 8'(to_cnt + 8'd1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 2'd0;
            bus.rsp_data  <= 32'd0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_wb_sequencer.sv
// Self-checking bench for neuron_wb_sequencer: driver tasks, a Wishbone slave model and
// scoreboard monitors comparing against a behavioural address/response model.
module tb_neuron_wb_sequencer;
  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  neuron_wb_sequencer_if bus ();

  neuron_wb_sequencer #(
    .BASE_ADDR   (32'h3000_0000),
    .TIMEOUT_CYC (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard queues: bus = {len[3:0], we, adr[31:0], dat[31:0]}, rsp = {err[1:0], data[31:0]}
  logic [68:0] bus_q[$];
  logic [33:0] rsp_q[$];

  int          ack_delay;
  logic [31:0] rd_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the core memory map
  function automatic void model(input int kind, input int idx, output bit legal,
                                output logic [31:0] adr, output bit we);
    int off;
    legal = 0; off = 0; we = 1;
    case (kind)
      0: begin legal = 1; off = idx * 4; end
      1: begin legal = (idx < 128) && (idx % 4 != 3); off = 'h1000 + (idx / 4) * 16 + (idx % 4) * 4; end
      2: begin legal = (idx < 16); off = 'h3000 + idx * 4; end
      3: begin legal = (idx == 0); off = 'h3100; end
      4: begin legal = (idx == 0); off = 'h2000; we = 0; end
      default: legal = 0;
    endcase
    adr = 32'h3000_0000 + off;
  endfunction

  // Wishbone slave: acks on the ack_delay-th stb cycle (0 = never); stray acks while idle
  initial begin
    int cnt;
    cnt = 0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
        cnt++;
        bus.wbm_ack_i = (cnt == ack_delay);
        bus.wbm_dat_i = rd_word;
      end else begin
        cnt = 0;
        bus.wbm_ack_i = ($urandom_range(0, 3) == 0);
        bus.wbm_dat_i = $urandom;
      end
    end
  end

  // bus monitor
  logic [68:0] cur;
  bit          in_cyc;
  int          cyc_len;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_cyc = 0;
    end else if (bus.wbm_cyc_o) begin
      if (!in_cyc) begin
        in_cyc  = 1;
        cyc_len = 0;
        if (bus_q.size() == 0) begin
          check("bus_unexpected_cycle", 64'(bus.wbm_cyc_o), 64'd0);
          cur = '0;
        end else begin
          cur = bus_q.pop_front();
          check("bus_adr", 64'(bus.wbm_adr_o), 64'(cur[63:32]));
          check("bus_we", 64'(bus.wbm_we_o), 64'(cur[64]));
          check("bus_dat", 64'(bus.wbm_dat_o), 64'(cur[31:0]));
          check("bus_sel", 64'(bus.wbm_sel_o), 64'hF);
        end
      end else begin
        check("bus_stable", {bus.wbm_adr_o, bus.wbm_dat_o}, {cur[63:32], cur[31:0]});
      end
      check("bus_stb", 64'(bus.wbm_stb_o), 64'd1);
      cyc_len++;
    end else begin
      if (in_cyc) begin
        check("bus_len", 64'(cyc_len), 64'(cur[68:65]));
        in_cyc = 0;
      end
      check("bus_idle_zero", {bus.wbm_stb_o, bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o}, 64'd0);
    end
  end

  // response monitor
  bit          prev_v;
  logic [33:0] prev_r;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 0;
    end else if (bus.rsp_valid) begin
      check("rsp_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
      if (prev_v) check("rsp_stable", 64'({bus.rsp_err, bus.rsp_data}), 64'(prev_r));
      if (bus.rsp_ready) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
        end else begin
          logic [33:0] e;
          e = rsp_q.pop_front();
          check("rsp_err", 64'(bus.rsp_err), 64'(e[33:32]));
          check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
        end
        prev_v = 0;
      end else begin
        prev_v = 1;
        prev_r = {bus.rsp_err, bus.rsp_data};
      end
    end else begin
      prev_v = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmd_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("cmd_ready_timeout", 64'(bus.cmd_ready), 64'd1);
  endtask

  // issue one command, push expectations, then consume its response after `hold` cycles
  task automatic do_cmd(input int kind, input int idx, input logic [31:0] data,
                        input int delay, input logic [31:0] rd, input int hold);
    bit          legal, we, ok;
    logic [31:0] adr;
    int          len;
    logic [1:0]  err;
    logic [31:0] rdat;
    model(kind, idx, legal, adr, we);
    ack_delay = delay;
    rd_word   = rd;
    len  = (delay >= 1 && delay <= TO) ? delay : TO;
    err  = !legal ? 2'd1 : (delay >= 1 && delay <= TO) ? 2'd0 : 2'd2;
    rdat = (err == 2'd0 && !we) ? rd : 32'd0;
    wait_ready(ok);
    if (!ok) return;
    if (legal) bus_q.push_back({4'(len), we, adr, we ? data : 32'd0});
    rsp_q.push_back({err, rdat});
    bus.cmd_valid = 1'b1;
    bus.cmd_kind  = 3'(kind);
    bus.cmd_idx   = 8'(idx);
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = $urandom;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      check("rsp_valid_timeout", 64'(bus.rsp_valid), 64'd1);
      return;
    end
    repeat (hold) tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    checks = 0; failures = 0;
    ack_delay = 0; rd_word = 0;
    bus.cmd_valid = 0; bus.cmd_kind = 0; bus.cmd_idx = 0; bus.cmd_data = 0;
    bus.rsp_ready = 0;
    rst_n = 1'b0;
    #12;
    check("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 64'd0);
    check("reset_cyc", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // directed cases
    do_cmd(0, 'h05, 32'hDEAD_BEEF, 2, 32'h0, 0);
    do_cmd(1, 'h7E, 32'h1234_5678, 1, 32'h0, 1);
    do_cmd(1, 'h7F, 32'h1111_1111, 1, 32'h0, 0);
    do_cmd(4, 0, 32'hFFFF_FFFF, 3, 32'h0000_00A5, 0);
    do_cmd(3, 0, 32'h0000_0001, 0, 32'h0, 0);
    do_cmd(2, 15, 32'hCAFE_0001, TO, 32'h0, 0);
    do_cmd(2, 16, 32'hCAFE_0002, 1, 32'h0, 0);
    do_cmd(4, 1, 32'h0, 1, 32'h5555_5555, 0);
    do_cmd(4, 0, 32'h0, TO + 1, 32'h7777_7777, 0);
    do_cmd(5, 0, 32'h0, 1, 32'h0, 0);
    do_cmd(0, 255, 32'hA5A5_A5A5, 1, 32'h0, 10);
    do_cmd(0, 0, 32'h0BAD_F00D, 1, 32'h0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int k, ix;
      k  = $urandom_range(0, 7);
      ix = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) :
           (k == 0 || k == 1) ? $urandom_range(0, 127) :
           (k == 2) ? $urandom_range(0, 15) : 0;
      do_cmd(k, ix, $urandom, $urandom_range(0, TO + 2), $urandom, $urandom_range(0, 3));
    end

    // reset during an active bus cycle
    wait_ready(ok);
    ack_delay = 0;
    bus_q.push_back({4'(TO), 1'b1, 32'h3000_0004, 32'h1357_9BDF});
    bus.cmd_valid = 1'b1; bus.cmd_kind = 3'd0; bus.cmd_idx = 8'd1; bus.cmd_data = 32'h1357_9BDF;
    tick();
    bus.cmd_valid = 1'b0;
    check("mid_cycle_cyc_high", 64'(bus.wbm_cyc_o), 64'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
    bus_q.delete();
    rsp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("after_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("after_reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("after_reset_state", 64'(dbg_state), 64'd0);
    do_cmd(4, 0, 32'h0, 2, 32'hFEED_0042, 0);

    repeat (3) tick();
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
